cmos_capture_v2: RTL and testbench

Parametrised pixel-capture front end for OV5640-class sensors, the successor to the fixed-size `cmos_decode_v1`. It sits between the sensor DVP pins and the display/processing path. It discards a configurable number of start-up frames and assembles byte pairs into RGB565. It expands RGB565 to RGB888 with MSB replication, tracks pixel and line coordinates, and flags malformed lines. An optional luma-threshold stage produces the binary-image output.

---
 rtl/cmos_pkg.sv | 20 ++
 rtl/cmos_capture_v2_if.sv | 30 +++
 rtl/rgb_to_bin.sv | 28 ++
 rtl/cmos_capture_v2.sv | 171 +++++++++++++++++
 tb/tb_cmos_capture_v2.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_pkg.sv
// cmos_pkg: capture state encoding, RGB565->RGB888 expansion and luma weights
// shared by cmos_capture_v2 and rgb_to_bin.
package cmos_pkg;

    typedef enum logic [1:0] {
        S_SKIP,
        S_WAIT,
        S_ACTIVE
    } cap_state_e;

    // BT.601-style weights scaled to sum to 256, so Y = sum >> 8 never exceeds 255.
    localparam logic [15:0] LUMA_R = 16'd77;
    localparam logic [15:0] LUMA_G = 16'd150;
    localparam logic [15:0] LUMA_B = 16'd29;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/cmos_capture_v2_if.sv
// cmos_capture_v2_if: DVP sensor pins and control in, aligned video and status out.
interface cmos_capture_v2_if #(
    parameter int CNT_W = 12
);
    logic             enable_i;
    logic             cmos_vsync_i;
    logic             cmos_href_i;
    logic [7:0]       cmos_data_i;
    logic [7:0]       thresh_i;
    logic             hs_o;
    logic             vs_o;
    logic             de_o;
    logic [23:0]      rgb_o;
    logic             bin_o;
    logic [CNT_W-1:0] x_o;
    logic [CNT_W-1:0] y_o;
    logic             frame_done_o;
    logic             line_err_o;

    modport master (
        output enable_i, cmos_vsync_i, cmos_href_i, cmos_data_i, thresh_i,
        input  hs_o, vs_o, de_o, rgb_o, bin_o, x_o, y_o, frame_done_o, line_err_o
    );

    modport slave (
        input  enable_i, cmos_vsync_i, cmos_href_i, cmos_data_i, thresh_i,
        output hs_o, vs_o, de_o, rgb_o, bin_o, x_o, y_o, frame_done_o, line_err_o
    );

endinterface

// File: rtl/rgb_to_bin.sv
// rgb_to_bin: registered luma (77R+150G+29B)>>8 compared against a threshold;
// the result is qualified by the pixel strobe so idle cycles read as 0.
module rgb_to_bin
    import cmos_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        de_i,
    input  logic [23:0] rgb_i,
    input  logic [7:0]  thresh_i,
    output logic        bin_o
);

    logic [15:0] y_sum;
    logic        bin_d, bin_q;

    always_comb begin
        y_sum = LUMA_R * 16'(rgb_i[23:16]) + LUMA_G * 16'(rgb_i[15:8]) + LUMA_B * 16'(rgb_i[7:0]);
        bin_d = de_i && (y_sum[15:8] >= thresh_i);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) bin_q <= 1'b0;
        else     bin_q <= bin_d;

    assign bin_o = bin_q;

endmodule

// File: rtl/cmos_capture_v2.sv
// cmos_capture_v2: DVP byte-pair capture to RGB888 with start-up frame skip, coordinates and line check.
// Define CMOS_BINARY_EN to add the luma-threshold stage (bin_o) and one extra cycle on every output.
module cmos_capture_v2
    import cmos_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int CNT_W       = 12
) (
    input logic              CLK_i,
    input logic              rst,
    cmos_capture_v2_if.slave bus
);

    localparam int SW = $clog2(SKIP_FRAMES + 2);

    if ((1 << CNT_W) <= ((IMG_W > IMG_H) ? IMG_W : IMG_H)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for IMG_W/IMG_H");
    end

    logic             vs_q, hs_q, vs_p_q, hs_p_q;
    logic [7:0]       dat_q, hi_q, hi_d;
    cap_state_e       state_q, state_d;
    logic [SW-1:0]    skip_q, skip_d;
    logic             phase_q, phase_d, err_q, err_d, fd_q, fd_d, de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d, xo_q, xo_d, yo_q, yo_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             fs, hfall, cap, ph;

    assign fs    = vs_q & ~vs_p_q;
    assign hfall = hs_p_q & ~hs_q;

    always_ff @(posedge CLK_i or posedge rst)
        if (rst) begin
            state_q <= (SKIP_FRAMES == 0) ? S_WAIT : S_SKIP;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (fs)
            case (state_q)
                S_SKIP: begin
                    skip_d  = skip_q + 1'b1;
                    state_d = (skip_d == SW'(SKIP_FRAMES)) ? S_WAIT : S_SKIP;
                end
                default: state_d = bus.enable_i ? S_ACTIVE : S_WAIT;
            endcase
    end

    // Frame start is applied first (bases below), so a byte in that same cycle is byte 0 of line 0.
    always_comb begin
        cap     = state_d == S_ACTIVE;
        ph      = phase_q & ~fs;
        fd_d    = fs && state_q == S_ACTIVE;
        x_d     = fs ? '0 : x_q;
        y_d     = fs ? '0 : y_q;
        err_d   = fs ? 1'b0 : err_q;
        phase_d = 1'b0;
        hi_d    = hi_q;
        de_d    = 1'b0;
        rgb_d   = rgb_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        if (cap && hs_q) begin
            phase_d = ~ph;
            if (!ph) hi_d = dat_q;
            else begin
                de_d  = 1'b1;
                rgb_d = rgb565_to_888({hi_q, dat_q});
                xo_d  = x_d;
                yo_d  = y_d;
                x_d   = (&x_d) ? x_d : x_d + 1'b1;
            end
        end else if (cap && hfall) begin
            if (x_d != '0) y_d = (&y_d) ? y_d : y_d + 1'b1;
            if (x_d != CNT_W'(IMG_W)) err_d = 1'b1;
            x_d = '0;
        end
    end

    always_ff @(posedge CLK_i or posedge rst)
        if (rst) begin
            {vs_q, hs_q, vs_p_q, hs_p_q} <= '0;
            {phase_q, err_q, fd_q, de_q} <= '0;
            dat_q <= '0;
            hi_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            xo_q  <= '0;
            yo_q  <= '0;
            rgb_q <= '0;
        end else begin
            vs_q    <= bus.cmos_vsync_i;
            hs_q    <= bus.cmos_href_i;
            dat_q   <= bus.cmos_data_i;
            vs_p_q  <= vs_q;
            hs_p_q  <= hs_q;
            phase_q <= phase_d;
            err_q   <= err_d;
            fd_q    <= fd_d;
            de_q    <= de_d;
            hi_q    <= hi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            rgb_q   <= rgb_d;
        end

`ifdef CMOS_BINARY_EN
    logic             hs2_q, vs2_q, de2_q, fd2_q, err2_q;
    logic [23:0]      rgb2_q;
    logic [CNT_W-1:0] xo2_q, yo2_q;

    // Delay everything by the luma stage so it stays aligned with bin_o.
    always_ff @(posedge CLK_i or posedge rst)
        if (rst) begin
            {hs2_q, vs2_q, de2_q, fd2_q, err2_q} <= '0;
            rgb2_q <= '0;
            xo2_q  <= '0;
            yo2_q  <= '0;
        end else begin
            hs2_q  <= hs_p_q;
            vs2_q  <= vs_p_q;
            de2_q  <= de_q;
            fd2_q  <= fd_q;
            err2_q <= err_q;
            rgb2_q <= rgb_q;
            xo2_q  <= xo_q;
            yo2_q  <= yo_q;
        end

    rgb_to_bin u_bin (
        .clk      (CLK_i),
        .rst      (rst),
        .de_i     (de_q),
        .rgb_i    (rgb_q),
        .thresh_i (bus.thresh_i),
        .bin_o    (bus.bin_o)
    );

    assign bus.hs_o         = hs2_q;
    assign bus.vs_o         = vs2_q;
    assign bus.de_o         = de2_q;
    assign bus.rgb_o        = rgb2_q;
    assign bus.x_o          = xo2_q;
    assign bus.y_o          = yo2_q;
    assign bus.frame_done_o = fd2_q;
    assign bus.line_err_o   = err2_q;
`else
    logic unused_thresh;

    assign unused_thresh    = ^bus.thresh_i;
    assign bus.bin_o        = 1'b0;
    assign bus.hs_o         = hs_p_q;
    assign bus.vs_o         = vs_p_q;
    assign bus.de_o         = de_q;
    assign bus.rgb_o        = rgb_q;
    assign bus.x_o          = xo_q;
    assign bus.y_o          = yo_q;
    assign bus.frame_done_o = fd_q;
    assign bus.line_err_o   = err_q;
`endif

endmodule

// File: tb/tb_cmos_capture_v2.sv
// tb_cmos_capture_v2: table-driven pixel vectors plus directed frame-skip, line-error,
// enable, frame-start/href overlap and mid-line reset sequences.
module tb_cmos_capture_v2;

    localparam int IMG_W = 4;
    localparam int IMG_H = 2;
    localparam int SKIP  = 2;
    localparam int CW    = 12;
`ifdef CMOS_BINARY_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [23:0] rgb;
        int          x;
        int          y;
        logic        bin;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic        hs;
        logic        bin;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   fd_cnt = 0;
    int   tests = 0;
    int   fails = 0;
    ev_t  evq[$];
    int   expc[$];
    vec_t tv[8];

    always #5 clk = ~clk;

    cmos_capture_v2_if #(.CNT_W(CW)) bus ();

    cmos_capture_v2 #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .SKIP_FRAMES (SKIP),
        .CNT_W       (CW)
    ) dut (
        .CLK_i (clk),
        .rst   (rst),
        .bus   (bus)
    );

    always @(posedge clk) begin
        ev_t e;
        cyc++;
        #1;
        if (bus.de_o) begin
            e.cyc = cyc;
            e.rgb = bus.rgb_o;
            e.x   = bus.x_o;
            e.y   = bus.y_o;
            e.hs  = bus.hs_o;
            e.bin = bus.bin_o;
            evq.push_back(e);
        end
        if (bus.frame_done_o) fd_cnt++;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        @(negedge clk);
        bus.cmos_vsync_i = v;
        bus.cmos_href_i  = h;
        bus.cmos_data_i  = d;
    endtask

    task automatic frame_start;
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        repeat (4) drive(1'b0, 1'b0, 8'h00);
    endtask

    // expc holds the cycle each completing byte sat on the pins
    task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo);
        drive(1'b0, 1'b1, hi);
        drive(1'b0, 1'b1, lo);
        expc.push_back(cyc);
    endtask

    task automatic end_line;
        repeat (4) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic plain_frame;
        frame_start();
        for (int l = 0; l < IMG_H; l++) begin
            for (int p = 0; p < IMG_W; p++) send_pix(8'h12, 8'h34);
            end_line();
        end
    endtask

    task automatic chk_all_zero(input string n);
        chk({n, "_ctl"}, {26'd0, bus.de_o, bus.hs_o, bus.vs_o, bus.frame_done_o, bus.line_err_o, bus.bin_o}, 32'd0);
        chk({n, "_rgb"}, {8'd0, bus.rgb_o}, 32'd0);
        chk({n, "_xy"}, {8'd0, bus.x_o, bus.y_o}, 32'd0);
    endtask

    initial begin
        int fd0;
        tv[0] = '{8'hF8, 8'h00, 24'hFF0000, 0, 0, 1'b0};
        tv[1] = '{8'h07, 8'hE0, 24'h00FF00, 1, 0, 1'b1};
        tv[2] = '{8'h00, 8'h1F, 24'h0000FF, 2, 0, 1'b0};
        tv[3] = '{8'hFF, 8'hFF, 24'hFFFFFF, 3, 0, 1'b1};
        tv[4] = '{8'h00, 8'h00, 24'h000000, 0, 1, 1'b0};
        tv[5] = '{8'h84, 8'h10, 24'h848284, 1, 1, 1'b1};
        tv[6] = '{8'hA5, 8'hA5, 24'hA5B629, 2, 1, 1'b1};
        tv[7] = '{8'h7B, 8'hEF, 24'h7B7D7B, 3, 1, 1'b0};

        bus.enable_i     = 1'b1;
        bus.thresh_i     = 8'd128;
        bus.cmos_vsync_i = 1'b0;
        bus.cmos_href_i  = 1'b0;
        bus.cmos_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Two start-up frames are discarded
        repeat (SKIP) plain_frame();
        chk("skip_de", evq.size(), 0);
        chk("skip_fd", fd_cnt, 0);
        evq.delete();
        expc.delete();

        // Frame 3: table vectors, 2 lines of 4 pixels
        frame_start();
        for (int i = 0; i < 8; i++) begin
            send_pix(tv[i].hi, tv[i].lo);
            if (i % 4 == 3) end_line();
        end
        chk("f3_de_count", evq.size(), 8);
        for (int i = 0; i < 8 && i < evq.size(); i++) begin
            chk($sformatf("rgb[%0d]", i), {8'd0, evq[i].rgb}, {8'd0, tv[i].rgb});
            chk($sformatf("x[%0d]", i), evq[i].x, tv[i].x);
            chk($sformatf("y[%0d]", i), evq[i].y, tv[i].y);
            chk($sformatf("lat[%0d]", i), evq[i].cyc - expc[i], LAT);
            chk($sformatf("hs[%0d]", i), evq[i].hs, 1);
`ifdef CMOS_BINARY_EN
            chk($sformatf("bin[%0d]", i), evq[i].bin, tv[i].bin);
`else
            chk($sformatf("bin[%0d]", i), evq[i].bin, 0);
`endif
        end
        chk("f3_fd", fd_cnt, 0);
        chk("f3_err", bus.line_err_o, 0);
        evq.delete();

        // 4th vsync rise closes frame 3; then a 7-byte line
        frame_start();
        chk("f4_fd", fd_cnt, 1);
        repeat (3) send_pix(8'hF8, 8'h00);
        drive(1'b0, 1'b1, 8'hAA);
        end_line();
        chk("odd_de_count", evq.size(), 3);
        if (evq.size() == 3) chk("odd_last_x", evq[2].x, 2);
        chk("odd_err_set", bus.line_err_o, 1);
        repeat (6) drive(1'b0, 1'b0, 8'h00);
        chk("odd_err_sticky", bus.line_err_o, 1);
        frame_start();
        chk("err_cleared", bus.line_err_o, 0);
        chk("f5_fd", fd_cnt, 2);
        evq.delete();

        // Disable mid-frame: frame 5 still completes
        for (int p = 0; p < IMG_W; p++) send_pix(8'h12, 8'h34);
        end_line();
        bus.enable_i = 1'b0;
        for (int p = 0; p < IMG_W; p++) send_pix(8'h12, 8'h34);
        end_line();
        chk("dis_full_frame", evq.size(), 8);
        frame_start();
        chk("dis_fd", fd_cnt, 3);
        for (int p = 0; p < IMG_W; p++) send_pix(8'h12, 8'h34);
        end_line();
        bus.enable_i = 1'b1;
        for (int p = 0; p < IMG_W; p++) send_pix(8'h12, 8'h34);
        end_line();
        chk("dis_no_de", evq.size(), 8);
        evq.delete();

        // Re-enable: frame start and href high in the same cycle
        drive(1'b1, 1'b1, 8'h07);
        drive(1'b0, 1'b1, 8'hE0);
        for (int p = 1; p < IMG_W; p++) send_pix(8'hF8, 8'h00);
        end_line();
        chk("ovl_de_count", evq.size(), 4);
        if (evq.size() == 4) begin
            chk("ovl_rgb0", {8'd0, evq[0].rgb}, 32'h0000FF00);
            chk("ovl_xy0", {evq[0].x, evq[0].y}, 0);
            chk("ovl_x3", evq[3].x, 3);
        end
        chk("ovl_no_fd", fd_cnt, 3);
        evq.delete();

        // Async reset mid-line
        send_pix(8'hFF, 8'hFF);
        send_pix(8'hFF, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        bus.cmos_href_i = 1'b0;
        end_line();
        evq.delete();
        fd0 = fd_cnt;
        repeat (SKIP) plain_frame();
        chk("reskip_de", evq.size(), 0);
        frame_start();
        for (int p = 0; p < IMG_W; p++) send_pix(8'h00, 8'h1F);
        end_line();
        chk("reskip_resume", evq.size(), 4);
        if (evq.size() == 4) chk("reskip_rgb", {8'd0, evq[3].rgb}, 32'h000000FF);
        chk("reskip_fd", fd_cnt - fd0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
